parity_frame_rx: RTL and testbench

- Serial frame receiver with parity check.
- Deserialises a start bit, DATA_W data bits (LSB first), one parity bit and one stop bit.
- Checks parity over data+parity bits and presents the word with error flags.
- Sits directly upstream of the combinational parity/flag logic: supplies it registered data bits plus a per-frame parity_err/frame_err result.

---
 rtl/parity_frame_rx.sv | 127 ++++++++++++
 tb/tb_parity_frame_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Advances only on bit_en strobes; publishes word and per-frame error flags with a one-clk valid.
module parity_frame_rx #(
   parameter int DATA_W     = 8,
   parameter bit ODD_PARITY = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bit_en,
   input  logic              rx,
   output logic [DATA_W-1:0] data_out,
   output logic              valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_PARITY = 3'd2,
      S_STOP   = 3'd3,
      S_BREAK  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                par_q, par_d;
   logic                perr_pend_q, perr_pend_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                perr_q, perr_d;
   logic                ferr_q, ferr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bit_en) begin
         case (state_q)
            S_IDLE:   if (!rx) state_d = S_DATA;
            S_DATA:   if (cnt_q == LAST_BIT) state_d = S_PARITY;
            S_PARITY: state_d = S_STOP;
            // A low stop bit parks in BREAK so a held-low line is not read as a new start.
            S_STOP:   state_d = rx ? S_IDLE : S_BREAK;
            S_BREAK:  if (rx) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      par_d       = par_q;
      perr_pend_d = perr_pend_q;
      data_d      = data_q;
      perr_d      = perr_q;
      ferr_d      = ferr_q;
      valid_d     = 1'b0;
      if (bit_en) begin
         case (state_q)
            S_IDLE: begin
               cnt_d = '0;
               par_d = 1'b0;
            end
            S_DATA: begin
               shift_d = {rx, shift_q[DATA_W-1:1]};
               par_d   = par_q ^ rx;
               cnt_d   = cnt_q + CNT_W'(1);
            end
            S_PARITY: begin
               perr_pend_d = par_q ^ rx ^ ODD_PARITY;
            end
            S_STOP: begin
               data_d  = shift_q;
               perr_d  = perr_pend_q;
               ferr_d  = ~rx;
               valid_d = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q     <= '0;
         cnt_q       <= '0;
         par_q       <= 1'b0;
         perr_pend_q <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         perr_q      <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         par_q       <= par_d;
         perr_pend_q <= perr_pend_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         perr_q      <= perr_d;
         ferr_q      <= ferr_d;
      end
   end

   always_comb begin
      busy       = (state_q != S_IDLE);
      data_out   = data_q;
      valid      = valid_q;
      parity_err = perr_q;
      frame_err  = ferr_q;
   end

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - directed bench for parity_frame_rx with a frame-level scoreboard.
// Second instance covers DATA_W=4 with odd parity and back-to-back frames.
module tb_parity_frame_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_en = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] data_out;
   logic       valid, parity_err, frame_err, busy;

   logic       bit_en2 = 1'b0;
   logic       rx2 = 1'b1;
   logic [3:0] data_out2;
   logic       valid2, parity_err2, frame_err2, busy2;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int stop_cyc = -10;

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       f;
   } exp_t;

   exp_t exp_q[$];
   exp_t pending_e;
   logic [7:0] m_data = '0;
   logic       m_perr = 1'b0;
   logic       m_ferr = 1'b0;

   int         v2_t[$];
   logic [3:0] v2_d[$];
   logic       v2_p[$];
   logic       v2_f[$];

   parity_frame_rx u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_en     (bit_en),
      .rx         (rx),
      .data_out   (data_out),
      .valid      (valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   parity_frame_rx #(.DATA_W(4), .ODD_PARITY(1'b1)) u_dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_en     (bit_en2),
      .rx         (rx2),
      .data_out   (data_out2),
      .valid      (valid2),
      .parity_err (parity_err2),
      .frame_err  (frame_err2),
      .busy       (busy2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Every cycle: valid only right after a stop strobe, flags/data held between frames.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_data = '0;
         m_perr = 1'b0;
         m_ferr = 1'b0;
         chk("rst_valid", valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_data", data_out, 0);
         chk("rst_perr", parity_err, 0);
         chk("rst_ferr", frame_err, 0);
      end else begin
         chk("valid_timing", valid, (cyc == stop_cyc) ? 1 : 0);
         if (cyc == stop_cyc) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               m_data = e.d;
               m_perr = e.p;
               m_ferr = e.f;
            end
         end
         chk("data_out", data_out, m_data);
         chk("parity_err", parity_err, m_perr);
         chk("frame_err", frame_err, m_ferr);
      end
   end

   always @(negedge clk) begin
      if (rst_n && valid2) begin
         v2_t.push_back(cyc);
         v2_d.push_back(data_out2);
         v2_p.push_back(parity_err2);
         v2_f.push_back(frame_err2);
      end
   end

   task automatic bit_period(input logic b, input int gap, input bit is_stop);
      rx = b;
      bit_en = 1'b1;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
      if (is_stop) begin
         stop_cyc = cyc;
         exp_q.push_back(pending_e);
      end
      for (int g = 0; g < gap; g++) begin
         rx = 1'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
      pending_e.d = d;
      pending_e.p = (^d) ^ p;
      pending_e.f = ~s;
      bit_period(1'b0, gap, 1'b0);
      for (int i = 0; i < 8; i++) bit_period(d[i], gap, 1'b0);
      bit_period(p, gap, 1'b0);
      bit_period(s, gap, 1'b1);
   endtask

   int bits2[14] = '{0, 1, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1};

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bit_period(1'b1, 0, 1'b0);
      bit_period(1'b1, 0, 1'b0);

      send_frame(8'hA5, 1'b0, 1'b1, 0);
      chk("a5_data", data_out, 8'hA5);
      chk("a5_perr", parity_err, 0);
      chk("a5_ferr", frame_err, 0);
      chk("a5_valid", valid, 1);
      chk("a5_busy", busy, 0);

      send_frame(8'h07, 1'b0, 1'b1, 0);
      chk("07p0_perr", parity_err, 1);
      send_frame(8'h07, 1'b1, 1'b1, 0);
      chk("07p1_perr", parity_err, 0);
      chk("07p1_data", data_out, 8'h07);

      send_frame(8'h3C, 1'b0, 1'b0, 0);
      chk("3c_ferr", frame_err, 1);
      chk("3c_busy_break", busy, 1);
      for (int i = 0; i < 3; i++) bit_period(1'b0, 0, 1'b0);
      bit_period(1'b1, 0, 1'b0);
      send_frame(8'h81, 1'b0, 1'b1, 0);
      chk("81_data", data_out, 8'h81);
      chk("81_ferr", frame_err, 0);

      send_frame(8'h5A, 1'b0, 1'b1, 3);
      chk("5a_data", data_out, 8'h5A);
      chk("5a_perr", parity_err, 0);

      bit_period(1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) bit_period(i[0], 0, 1'b0);
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_data", data_out, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bit_period(1'b1, 0, 1'b0);
      send_frame(8'h12, 1'b0, 1'b1, 0);
      chk("12_data", data_out, 8'h12);
      chk("12_perr", parity_err, 0);
      bit_period(1'b1, 2, 1'b0);
      chk("pending_frames", exp_q.size(), 0);

      bit_en2 = 1'b1;
      for (int i = 0; i < 14; i++) begin
         rx2 = bits2[i][0];
         @(posedge clk);
         #1;
      end
      rx2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bit_en2 = 1'b0;
      chk("w4_count", v2_t.size(), 2);
      if (v2_t.size() == 2) begin
         chk("w4_gap", v2_t[1] - v2_t[0], 7);
         chk("w4_d0", v2_d[0], 4'hB);
         chk("w4_p0", v2_p[0], 0);
         chk("w4_f0", v2_f[0], 0);
         chk("w4_d1", v2_d[1], 4'h3);
         chk("w4_p1", v2_p[1], 0);
      end
      chk("w4_busy", busy2, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
